// File: rtl/frame_fifo.sv
// ---------------------------------------------------------------------------
// frame_fifo : store-and-forward frame FIFO with atomic drop of bad frames.
// Optional statistics outputs are enabled with FRAME_FIFO_STATS_EN.
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module frame_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int FCNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  input  logic                  wr_err,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  frame_avail,
  output logic [FCNT_WIDTH-1:0] frame_cnt,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  drop_pulse
`ifdef FRAME_FIFO_STATS_EN
  ,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           ovf_cnt,
  output logic [ADDR_WIDTH:0]   max_level
`endif
);

  localparam int                   DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]  DEPTH_L  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]  PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [FCNT_WIDTH-1:0] FCNT_MAX = {FCNT_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    S_WRITE = 1'b0,
    S_DROP  = 1'b1
  } wstate_t;

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr, cm_ptr, rd_ptr;
  wstate_t             state;

  logic wr_en, commit, drop_now, ovf_now, load, last_hs;

  assign level       = wr_ptr - rd_ptr;
  assign full        = (level == DEPTH_L);
  assign frame_avail = |frame_cnt;

  assign wr_en   = (state == S_WRITE) && wr_valid && !full;
  assign commit  = wr_en && wr_last && !wr_err;
  assign load    = (!rd_valid || rd_ready) && (rd_ptr != cm_ptr);
  assign last_hs = rd_valid && rd_ready && rd_last;

  // A drop in DROP state or on a full FIFO is an overflow; otherwise it is wr_err.
  always_comb begin
    drop_now = 1'b0;
    ovf_now  = 1'b0;
    if (wr_valid && wr_last) begin
      if (state == S_DROP || full) begin
        drop_now = 1'b1;
        ovf_now  = 1'b1;
      end else if (wr_err) begin
        drop_now = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {wr_last, wr_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      cm_ptr     <= '0;
      state      <= S_WRITE;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop_now;
      if (drop_now)   wr_ptr <= cm_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (commit)     cm_ptr <= wr_ptr + PTR_ONE;
      case (state)
        S_WRITE: if (wr_valid && full && !wr_last) state <= S_DROP;
        S_DROP:  if (wr_valid && wr_last)          state <= S_WRITE;
        default: state <= S_WRITE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
    end else if (load) begin
      {rd_last, rd_data} <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      rd_ptr             <= rd_ptr + PTR_ONE;
      rd_valid           <= 1'b1;
    end else if (rd_valid && rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

  // A commit coinciding with a last-word handshake leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (commit && !last_hs) begin
      if (frame_cnt != FCNT_MAX) frame_cnt <= frame_cnt + 1'b1;
    end else if (last_hs && !commit && frame_cnt != '0) begin
      frame_cnt <= frame_cnt - 1'b1;
    end
  end

`ifdef FRAME_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt  <= '0;
      ovf_cnt   <= '0;
      max_level <= '0;
    end else begin
      if (drop_now && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (ovf_now && ovf_cnt != 16'hFFFF)   ovf_cnt  <= ovf_cnt + 16'd1;
      if (level > max_level)                max_level <= level;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_frame_fifo.sv
// ---------------------------------------------------------------------------
// tb_frame_fifo : directed + random bench for frame_fifo against a queue model.
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_frame_fifo;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0, wr_last = 1'b0, wr_err = 1'b0, rd_ready = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_valid, rd_last, frame_avail, full, drop_pulse;
  logic [7:0] rd_data, frame_cnt;
  logic [AW:0] level;
`ifdef FRAME_FIFO_STATS_EN
  logic [15:0] drop_cnt, ovf_cnt;
  logic [AW:0] max_level;
`endif

  frame_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(AW), .FCNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_err(wr_err),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .frame_avail(frame_avail), .frame_cnt(frame_cnt), .level(level), .full(full),
    .drop_pulse(drop_pulse)
`ifdef FRAME_FIFO_STATS_EN
    , .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt), .max_level(max_level)
`endif
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Reference model: committed words waiting in RAM, the frame being written,
  // and the output register.
  logic [8:0] cq[$];
  logic [8:0] pq[$];
  bit         m_ov = 0, m_ol = 0, m_dropping = 0, m_drop = 0;
  logic [7:0] m_od = 8'h00;
  int         m_fc = 0;
  int         m_dcnt = 0, m_ocnt = 0, m_max = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("rd_valid", 32'(rd_valid), 32'(m_ov));
    chk("rd_data", 32'(rd_data), 32'(m_od));
    chk("rd_last", 32'(rd_last), 32'(m_ol));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
    chk("frame_avail", 32'(frame_avail), 32'(m_fc != 0));
    chk("level", 32'(level), 32'(cq.size() + pq.size()));
    chk("full", 32'(full), 32'((cq.size() + pq.size()) == DEPTH));
    chk("drop_pulse", 32'(drop_pulse), 32'(m_drop));
`ifdef FRAME_FIFO_STATS_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(m_dcnt));
    chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ocnt));
    chk("max_level", 32'(max_level), 32'(m_max));
`endif
  endtask

  // Advance one clock, updating the model from the inputs currently applied.
  task automatic cycle();
    int         lvl;
    bit         fl, hs_last, load, commit, ovf;
    logic [8:0] w;
    lvl     = cq.size() + pq.size();
    fl      = (lvl == DEPTH);
    hs_last = m_ov && rd_ready && m_ol;
    load    = (!m_ov || rd_ready) && (cq.size() > 0);
    commit  = 0;
    m_drop  = 0;
    ovf     = 0;
    if (lvl > m_max) m_max = lvl;
    if (load) begin
      w = cq.pop_front();
      {m_ol, m_od} = w;
      m_ov = 1;
    end else if (m_ov && rd_ready) begin
      m_ov = 0;
    end
    if (wr_valid) begin
      if (m_dropping) begin
        if (wr_last) begin m_dropping = 0; m_drop = 1; ovf = 1; end
      end else if (fl) begin
        if (wr_last) begin m_drop = 1; ovf = 1; end
        else m_dropping = 1;
      end else if (wr_last && wr_err) begin
        m_drop = 1;
      end else begin
        pq.push_back({wr_last, wr_data});
        commit = wr_last;
      end
    end
    if (m_drop) pq.delete();
    if (commit) begin
      foreach (pq[i]) cq.push_back(pq[i]);
      pq.delete();
    end
    if (commit && !hs_last) begin
      if (m_fc < 255) m_fc++;
    end else if (hs_last && !commit && m_fc > 0) begin
      m_fc--;
    end
    if (m_drop && m_dcnt < 65535) m_dcnt++;
    if (ovf && m_ocnt < 65535) m_ocnt++;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit l, input bit e, input bit r);
    wr_valid = v; wr_data = d; wr_last = l; wr_err = e; rd_ready = r;
    cycle();
  endtask

  // rmode: 0 = rd_ready low, 1 = high, 2 = random
  task automatic send_frame(input int n, input bit err, input int rmode);
    for (int i = 0; i < n; i++)
      drive(1, 8'($urandom), i == n - 1, err && (i == n - 1),
            rmode == 2 ? 1'($urandom) : rmode == 1);
  endtask

  task automatic idle(input int n, input int rmode);
    for (int i = 0; i < n; i++)
      drive(0, 8'h00, 0, 0, rmode == 2 ? 1'($urandom) : rmode == 1);
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    cq.delete(); pq.delete();
    m_ov = 0; m_ol = 0; m_od = 8'h00; m_fc = 0; m_dropping = 0; m_drop = 0;
    m_dcnt = 0; m_ocnt = 0; m_max = 0;
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check_outputs();
  endtask

  initial begin
    do_reset();

    // Frame 01..05 with reader ready: valid two edges after the last write.
    for (int i = 1; i <= 5; i++) drive(1, 8'(i), i == 5, 0, 1);
    chk("t1_valid_after_commit", 32'(rd_valid), 32'd0);
    chk("t1_fcnt_after_commit", 32'(frame_cnt), 32'd1);
    drive(0, 8'h00, 0, 0, 1);
    chk("t1_first_word", 32'(rd_data), 32'h01);
    chk("t1_first_valid", 32'(rd_valid), 32'd1);
    idle(6, 1);
    chk("t1_level_end", 32'(level), 32'd0);
    chk("t1_fcnt_end", 32'(frame_cnt), 32'd0);

    // Errored frame is dropped.
    send_frame(4, 1, 1);
    chk("t2_drop_pulse", 32'(drop_pulse), 32'd1);
    idle(3, 1);
    chk("t2_valid", 32'(rd_valid), 32'd0);

    // Overflow: A commits, B overruns and is dropped, drain yields A only.
    send_frame(10, 0, 0);
    send_frame(10, 0, 0);
    idle(2, 0);
    idle(14, 1);
    chk("t3_level_end", 32'(level), 32'd0);

    // Back-pressure hold then toggling ready.
    send_frame(6, 0, 0);
    idle(5, 0);
    idle(20, 2);
    idle(6, 1);

    // 40 back-to-back 3-byte frames with concurrent reads.
    for (int f = 0; f < 40; f++) send_frame(3, 0, 1);
    idle(8, 1);
    chk("t5_fcnt_end", 32'(frame_cnt), 32'd0);

    // Reset mid-frame and mid-read, then a 2-byte frame.
    send_frame(4, 0, 0);
    drive(1, 8'hAA, 0, 0, 0);
    do_reset();
    send_frame(2, 0, 1);
    idle(5, 1);

    // Random traffic including errors, overflows and back-pressure.
    for (int k = 0; k < 600; k++)
      drive(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0));
    drive(1, 8'h00, 1, 0, 1);
    idle(25, 1);
    chk("rand_level_end", 32'(level), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

`default_nettype wire
